// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : Memory pipeline stage between Execute and Writeback.
//             Pass-through for ALU ops; req/ack data-memory access with timeout.
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage #(
   parameter int REG_WIDTH    = 16,
   parameter int PC_WIDTH     = 16,
   parameter int OPCODE_WIDTH = 8,
   parameter int IR_WIDTH     = 32,
   parameter int TIMEOUT      = 255,
   parameter logic [OPCODE_WIDTH-1:0] OP_LDB = 'h20,
   parameter logic [OPCODE_WIDTH-1:0] OP_LDW = 'h21,
   parameter logic [OPCODE_WIDTH-1:0] OP_STB = 'h22,
   parameter logic [OPCODE_WIDTH-1:0] OP_STW = 'h23
) (
   input  logic                    I_CLOCK,
   input  logic                    I_RESET_N,
   input  logic                    I_LOCK,
   input  logic                    I_EX_Valid,
   input  logic [PC_WIDTH-1:0]     I_PC,
   input  logic [OPCODE_WIDTH-1:0] I_Opcode,
   input  logic [IR_WIDTH-1:0]     I_IR,
   input  logic [3:0]              I_DestRegIdx,
   input  logic [REG_WIDTH-1:0]    I_DestValue,
   input  logic [2:0]              I_CCValue,
   input  logic [REG_WIDTH-1:0]    I_MARValue,
   input  logic [REG_WIDTH-1:0]    I_MDRValue,
   input  logic                    I_RegWEn,
   input  logic                    I_CCWEn,
   output logic                    O_DMemReq,
   output logic                    O_DMemWe,
   output logic [REG_WIDTH-1:0]    O_DMemAddr,
   output logic [REG_WIDTH-1:0]    O_DMemWData,
   output logic [1:0]              O_DMemByteEn,
   input  logic                    I_DMemAck,
   input  logic [REG_WIDTH-1:0]    I_DMemRData,
   output logic                    O_MEMStall,
   output logic                    O_LOCK,
   output logic                    O_MEM_Valid,
   output logic                    O_RegWEn,
   output logic                    O_CCWEn,
   output logic [PC_WIDTH-1:0]     O_PC,
   output logic [OPCODE_WIDTH-1:0] O_Opcode,
   output logic [IR_WIDTH-1:0]     O_IR,
   output logic [3:0]              O_DestRegIdx,
   output logic [REG_WIDTH-1:0]    O_DestValue,
   output logic [2:0]              O_CCValue,
   output logic                    O_MemErr
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;

   logic                    lock_q;
   logic                    valid_q, valid_d;
   logic                    regwen_q, regwen_d;
   logic                    ccwen_q, ccwen_d;
   logic [PC_WIDTH-1:0]     pc_q, pc_d;
   logic [OPCODE_WIDTH-1:0] op_q, op_d;
   logic [IR_WIDTH-1:0]     ir_q, ir_d;
   logic [3:0]              idx_q, idx_d;
   logic [REG_WIDTH-1:0]    dv_q, dv_d;
   logic [2:0]              cc_q, cc_d;
   logic                    err_q, err_d;
   logic                    req_q, req_d;
   logic                    we_q, we_d;
   logic [REG_WIDTH-1:0]    addr_q, addr_d;
   logic [REG_WIDTH-1:0]    wdata_q, wdata_d;
   logic [1:0]              be_q, be_d;

   // Fields of the outstanding memory instruction, replayed at completion.
   logic [PC_WIDTH-1:0]     h_pc_q, h_pc_d;
   logic [OPCODE_WIDTH-1:0] h_op_q, h_op_d;
   logic [IR_WIDTH-1:0]     h_ir_q, h_ir_d;
   logic [3:0]              h_idx_q, h_idx_d;
   logic [REG_WIDTH-1:0]    h_dv_q, h_dv_d;
   logic [2:0]              h_cc_q, h_cc_d;
   logic                    h_rwen_q, h_rwen_d;
   logic                    h_lo_q, h_lo_d;

   logic                    w_accept;
   logic                    w_is_mem;
   logic                    w_is_store;
   logic                    w_is_byte_st;
   logic                    w_wait_last;
   logic                    w_h_load;
   logic [REG_WIDTH-1:0]    w_ld_data;

   assign w_accept     = I_LOCK & I_EX_Valid;
   assign w_is_store   = (I_Opcode == OP_STB) || (I_Opcode == OP_STW);
   assign w_is_mem     = (I_Opcode == OP_LDB) || (I_Opcode == OP_LDW) || w_is_store;
   assign w_is_byte_st = (I_Opcode == OP_STB);
   assign w_wait_last  = (cnt_q == CNT_LAST);
   assign w_h_load     = (h_op_q == OP_LDB) || (h_op_q == OP_LDW);

   // Byte loads pick the lane addressed by the original MAR bit 0.
   always_comb begin
      w_ld_data = I_DMemRData;
      if (h_op_q == OP_LDB) begin
         w_ld_data = {{(REG_WIDTH-8){1'b0}},
                      (h_lo_q ? I_DMemRData[15:8] : I_DMemRData[7:0])};
      end
   end

   assign O_MEMStall = ((state_q == S_IDLE) && w_accept && w_is_mem) ||
                       ((state_q == S_WAIT) && !I_DMemAck && !w_wait_last);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      valid_d  = valid_q;
      regwen_d = regwen_q;
      ccwen_d  = ccwen_q;
      pc_d     = pc_q;
      op_d     = op_q;
      ir_d     = ir_q;
      idx_d    = idx_q;
      dv_d     = dv_q;
      cc_d     = cc_q;
      err_d    = 1'b0;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      h_pc_d   = h_pc_q;
      h_op_d   = h_op_q;
      h_ir_d   = h_ir_q;
      h_idx_d  = h_idx_q;
      h_dv_d   = h_dv_q;
      h_cc_d   = h_cc_q;
      h_rwen_d = h_rwen_q;
      h_lo_d   = h_lo_q;

      case (state_q)
         S_IDLE: begin
            if (!w_accept) begin
               valid_d  = 1'b0;
               regwen_d = 1'b0;
               ccwen_d  = 1'b0;
            end else if (!w_is_mem) begin
               valid_d  = 1'b1;
               regwen_d = I_RegWEn;
               ccwen_d  = I_CCWEn;
               pc_d     = I_PC;
               op_d     = I_Opcode;
               ir_d     = I_IR;
               idx_d    = I_DestRegIdx;
               dv_d     = I_DestValue;
               cc_d     = I_CCValue;
            end else begin
               valid_d  = 1'b0;
               regwen_d = 1'b0;
               ccwen_d  = 1'b0;
               h_pc_d   = I_PC;
               h_op_d   = I_Opcode;
               h_ir_d   = I_IR;
               h_idx_d  = I_DestRegIdx;
               h_dv_d   = I_DestValue;
               h_cc_d   = I_CCValue;
               h_rwen_d = I_RegWEn;
               h_lo_d   = I_MARValue[0];
               req_d    = 1'b1;
               we_d     = w_is_store;
               addr_d   = {I_MARValue[REG_WIDTH-1:1], 1'b0};
               if (w_is_byte_st) begin
                  wdata_d = {(REG_WIDTH/8){I_MDRValue[7:0]}};
                  be_d    = I_MARValue[0] ? 2'b10 : 2'b01;
               end else begin
                  wdata_d = I_MDRValue;
                  be_d    = 2'b11;
               end
               cnt_d    = '0;
               state_d  = S_WAIT;
            end
         end

         S_WAIT: begin
            if (I_DMemAck || w_wait_last) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               req_d   = 1'b0;
               valid_d = 1'b1;
               ccwen_d = 1'b0;
               pc_d    = h_pc_q;
               op_d    = h_op_q;
               ir_d    = h_ir_q;
               idx_d   = h_idx_q;
               cc_d    = h_cc_q;
               // An ack on the last permitted cycle still wins over timeout.
               if (I_DMemAck) begin
                  if (w_h_load) begin
                     dv_d     = w_ld_data;
                     regwen_d = h_rwen_q;
                  end else begin
                     dv_d     = h_dv_q;
                     regwen_d = 1'b0;
                  end
               end else begin
                  err_d    = 1'b1;
                  dv_d     = '0;
                  regwen_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         lock_q   <= 1'b0;
         valid_q  <= 1'b0;
         regwen_q <= 1'b0;
         ccwen_q  <= 1'b0;
         pc_q     <= '0;
         op_q     <= '0;
         ir_q     <= '0;
         idx_q    <= '0;
         dv_q     <= '0;
         cc_q     <= '0;
         err_q    <= 1'b0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         h_pc_q   <= '0;
         h_op_q   <= '0;
         h_ir_q   <= '0;
         h_idx_q  <= '0;
         h_dv_q   <= '0;
         h_cc_q   <= '0;
         h_rwen_q <= 1'b0;
         h_lo_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lock_q   <= I_LOCK;
         valid_q  <= valid_d;
         regwen_q <= regwen_d;
         ccwen_q  <= ccwen_d;
         pc_q     <= pc_d;
         op_q     <= op_d;
         ir_q     <= ir_d;
         idx_q    <= idx_d;
         dv_q     <= dv_d;
         cc_q     <= cc_d;
         err_q    <= err_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         h_pc_q   <= h_pc_d;
         h_op_q   <= h_op_d;
         h_ir_q   <= h_ir_d;
         h_idx_q  <= h_idx_d;
         h_dv_q   <= h_dv_d;
         h_cc_q   <= h_cc_d;
         h_rwen_q <= h_rwen_d;
         h_lo_q   <= h_lo_d;
      end
   end

   assign O_DMemReq    = req_q;
   assign O_DMemWe     = we_q;
   assign O_DMemAddr   = addr_q;
   assign O_DMemWData  = wdata_q;
   assign O_DMemByteEn = be_q;
   assign O_LOCK       = lock_q;
   assign O_MEM_Valid  = valid_q;
   assign O_RegWEn     = regwen_q;
   assign O_CCWEn      = ccwen_q;
   assign O_PC         = pc_q;
   assign O_Opcode     = op_q;
   assign O_IR         = ir_q;
   assign O_DestRegIdx = idx_q;
   assign O_DestValue  = dv_q;
   assign O_CCValue    = cc_q;
   assign O_MemErr     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : scoreboard bench for mem_stage (TIMEOUT = 4, negedge design).
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

   localparam int TO = 4;
   localparam logic [7:0] C_ADD = 8'h01;
   localparam logic [7:0] C_LDB = 8'h20;
   localparam logic [7:0] C_LDW = 8'h21;
   localparam logic [7:0] C_STB = 8'h22;
   localparam logic [7:0] C_STW = 8'h23;

   logic        I_CLOCK = 1'b1;
   logic        I_RESET_N;
   logic        I_LOCK, I_EX_Valid;
   logic [15:0] I_PC;
   logic [7:0]  I_Opcode;
   logic [31:0] I_IR;
   logic [3:0]  I_DestRegIdx;
   logic [15:0] I_DestValue;
   logic [2:0]  I_CCValue;
   logic [15:0] I_MARValue, I_MDRValue;
   logic        I_RegWEn, I_CCWEn;
   logic        O_DMemReq, O_DMemWe;
   logic [15:0] O_DMemAddr, O_DMemWData;
   logic [1:0]  O_DMemByteEn;
   logic        I_DMemAck;
   logic [15:0] I_DMemRData;
   logic        O_MEMStall, O_LOCK, O_MEM_Valid, O_RegWEn, O_CCWEn;
   logic [15:0] O_PC;
   logic [7:0]  O_Opcode;
   logic [31:0] O_IR;
   logic [3:0]  O_DestRegIdx;
   logic [15:0] O_DestValue;
   logic [2:0]  O_CCValue;
   logic        O_MemErr;

   mem_stage #(
      .REG_WIDTH(16), .PC_WIDTH(16), .OPCODE_WIDTH(8), .IR_WIDTH(32), .TIMEOUT(TO),
      .OP_LDB(C_LDB), .OP_LDW(C_LDW), .OP_STB(C_STB), .OP_STW(C_STW)
   ) u_dut (
      .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK), .I_EX_Valid(I_EX_Valid),
      .I_PC(I_PC), .I_Opcode(I_Opcode), .I_IR(I_IR), .I_DestRegIdx(I_DestRegIdx),
      .I_DestValue(I_DestValue), .I_CCValue(I_CCValue), .I_MARValue(I_MARValue),
      .I_MDRValue(I_MDRValue), .I_RegWEn(I_RegWEn), .I_CCWEn(I_CCWEn),
      .O_DMemReq(O_DMemReq), .O_DMemWe(O_DMemWe), .O_DMemAddr(O_DMemAddr),
      .O_DMemWData(O_DMemWData), .O_DMemByteEn(O_DMemByteEn), .I_DMemAck(I_DMemAck),
      .I_DMemRData(I_DMemRData), .O_MEMStall(O_MEMStall), .O_LOCK(O_LOCK),
      .O_MEM_Valid(O_MEM_Valid), .O_RegWEn(O_RegWEn), .O_CCWEn(O_CCWEn), .O_PC(O_PC),
      .O_Opcode(O_Opcode), .O_IR(O_IR), .O_DestRegIdx(O_DestRegIdx),
      .O_DestValue(O_DestValue), .O_CCValue(O_CCValue), .O_MemErr(O_MemErr)
   );

   always #5 I_CLOCK = ~I_CLOCK;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] dv;
      logic        chk_dv;
      logic        rwen;
      logic        ccwen;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Writeback-side monitor: every retired instruction must match the scoreboard head.
   always @(posedge I_CLOCK) begin
      if (I_RESET_N === 1'b1) begin
         if (O_MEM_Valid) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_valid", {16'h0, O_PC}, 32'hFFFF_FFFF);
            end else begin
               mon_e = sb.pop_front();
               check_eq("wb_pc", {16'h0, O_PC}, {16'h0, mon_e.pc});
               if (mon_e.chk_dv) check_eq("wb_destvalue", {16'h0, O_DestValue}, {16'h0, mon_e.dv});
               check_eq("wb_regwen", {31'h0, O_RegWEn}, {31'h0, mon_e.rwen});
               check_eq("wb_ccwen", {31'h0, O_CCWEn}, {31'h0, mon_e.ccwen});
               check_eq("wb_memerr", {31'h0, O_MemErr}, {31'h0, mon_e.err});
            end
         end else if (O_MemErr) begin
            check_eq("memerr_without_valid", {31'h0, O_MemErr}, 32'h0);
         end
      end
   end

   task automatic run_alu(input logic [15:0] pc, input logic [15:0] dv,
                          input logic rwen, input logic ccwen, input logic lock);
      exp_t e;
      @(negedge I_CLOCK); #1;
      I_LOCK = lock; I_EX_Valid = 1'b1; I_Opcode = C_ADD; I_PC = pc;
      I_DestValue = dv; I_RegWEn = rwen; I_CCWEn = ccwen; I_IR = {pc, pc};
      I_MARValue = 16'h0011; I_MDRValue = 16'h5555;
      if (lock) begin
         e = '{pc: pc, dv: dv, chk_dv: 1'b1, rwen: rwen, ccwen: ccwen, err: 1'b0};
         sb.push_back(e);
      end
      @(posedge I_CLOCK);
      check_eq("alu_stall", {31'h0, O_MEMStall}, 32'h0);
      @(negedge I_CLOCK); #1;
      I_EX_Valid = 1'b0; I_LOCK = 1'b1;
      @(posedge I_CLOCK);
      check_eq("o_lock", {31'h0, O_LOCK}, {31'h0, lock});
      check_eq("alu_req", {31'h0, O_DMemReq}, 32'h0);
   endtask

   task automatic run_mem(input logic [7:0] op, input logic [15:0] pc, input logic [15:0] mar,
                          input logic [15:0] mdr, input logic rwen, input int ack_at,
                          input logic [15:0] rdata);
      exp_t        e;
      logic        is_load, acked;
      logic [15:0] exp_addr, exp_wd;
      logic [1:0]  exp_be;
      int          stalls, exp_stalls;
      is_load  = (op == C_LDB) || (op == C_LDW);
      acked    = (ack_at >= 1) && (ack_at <= TO);
      exp_addr = {mar[15:1], 1'b0};
      exp_wd   = (op == C_STB) ? {mdr[7:0], mdr[7:0]} : mdr;
      exp_be   = (op == C_STB) ? (mar[0] ? 2'b10 : 2'b01) : 2'b11;
      e.pc = pc; e.ccwen = 1'b0;
      if (!acked) begin
         e.dv = 16'h0; e.chk_dv = 1'b1; e.rwen = 1'b0; e.err = 1'b1;
      end else if (is_load) begin
         e.dv = (op == C_LDW) ? rdata : {8'h00, (mar[0] ? rdata[15:8] : rdata[7:0])};
         e.chk_dv = 1'b1; e.rwen = rwen; e.err = 1'b0;
      end else begin
         e.dv = 16'h0; e.chk_dv = 1'b0; e.rwen = 1'b0; e.err = 1'b0;
      end
      exp_stalls = acked ? ack_at : TO;

      @(negedge I_CLOCK); #1;
      I_LOCK = 1'b1; I_EX_Valid = 1'b1; I_Opcode = op; I_PC = pc; I_IR = {pc, 16'hA0A0};
      I_MARValue = mar; I_MDRValue = mdr; I_RegWEn = rwen; I_CCWEn = 1'b1;
      I_DestValue = 16'hDEAD; I_DestRegIdx = 4'h3;
      sb.push_back(e);
      @(posedge I_CLOCK);
      check_eq("issue_stall", {31'h0, O_MEMStall}, 32'h1);
      check_eq("issue_req_low", {31'h0, O_DMemReq}, 32'h0);
      stalls = 1;
      for (int w = 1; w <= TO; w++) begin
         @(negedge I_CLOCK); #1;
         I_EX_Valid = 1'b0;
         I_DMemAck   = (w == ack_at);
         I_DMemRData = (w == ack_at) ? rdata : 16'hFFFF;
         @(posedge I_CLOCK);
         check_eq("wait_req", {31'h0, O_DMemReq}, 32'h1);
         check_eq("wait_addr", {16'h0, O_DMemAddr}, {16'h0, exp_addr});
         check_eq("wait_we", {31'h0, O_DMemWe}, {31'h0, ~is_load});
         if (op != C_LDB) check_eq("wait_byteen", {30'h0, O_DMemByteEn}, {30'h0, exp_be});
         if (!is_load) check_eq("wait_wdata", {16'h0, O_DMemWData}, {16'h0, exp_wd});
         check_eq("wait_stall", {31'h0, O_MEMStall}, {31'h0, ((w != ack_at) && (w != TO))});
         stalls += int'(O_MEMStall);
         if (w == ack_at) break;
      end
      @(negedge I_CLOCK); #1;
      I_DMemAck = 1'b0;
      @(posedge I_CLOCK);
      check_eq("done_req", {31'h0, O_DMemReq}, 32'h0);
      check_eq("done_stall", {31'h0, O_MEMStall}, 32'h0);
      check_eq("stall_edges", stalls, exp_stalls);
   endtask

   initial begin
      I_RESET_N = 1'b0; I_LOCK = 1'b0; I_EX_Valid = 1'b0; I_PC = '0; I_Opcode = C_ADD;
      I_IR = '0; I_DestRegIdx = '0; I_DestValue = '0; I_CCValue = 3'b010;
      I_MARValue = '0; I_MDRValue = '0; I_RegWEn = 1'b0; I_CCWEn = 1'b0;
      I_DMemAck = 1'b0; I_DMemRData = '0;
      repeat (2) @(negedge I_CLOCK);
      I_LOCK = 1'b1;
      @(posedge I_CLOCK);
      check_eq("rst_req", {31'h0, O_DMemReq}, 32'h0);
      check_eq("rst_valid", {31'h0, O_MEM_Valid}, 32'h0);
      check_eq("rst_memerr", {31'h0, O_MemErr}, 32'h0);
      check_eq("rst_destvalue", {16'h0, O_DestValue}, 32'h0);
      check_eq("rst_lock", {31'h0, O_LOCK}, 32'h0);
      I_RESET_N = 1'b1;

      run_alu(16'h0100, 16'h0042, 1'b1, 1'b1, 1'b1);
      run_alu(16'h0102, 16'h0077, 1'b1, 1'b0, 1'b0);
      run_mem(C_LDW, 16'h0104, 16'h0011, 16'h0000, 1'b1, 4, 16'hBEEF);
      run_mem(C_LDB, 16'h0106, 16'h0021, 16'h0000, 1'b1, 1, 16'hA55A);
      run_mem(C_LDB, 16'h0108, 16'h0020, 16'h0000, 1'b1, 2, 16'hA55A);
      run_mem(C_STB, 16'h010A, 16'h0004, 16'h1234, 1'b1, 2, 16'h0000);
      run_mem(C_STB, 16'h010C, 16'h0005, 16'h12AB, 1'b1, 1, 16'h0000);
      run_mem(C_STW, 16'h010E, 16'h0006, 16'hCAFE, 1'b1, 3, 16'h0000);
      run_mem(C_LDW, 16'h0110, 16'h0030, 16'h0000, 1'b1, 0, 16'h0000);
      run_mem(C_LDW, 16'h0112, 16'h0032, 16'h0000, 1'b1, 2, 16'h1357);
      run_alu(16'h0114, 16'h0099, 1'b0, 1'b1, 1'b1);

      // Reset in the middle of an outstanding load; nothing may retire from it.
      @(negedge I_CLOCK); #1;
      I_LOCK = 1'b1; I_EX_Valid = 1'b1; I_Opcode = C_LDW; I_PC = 16'h0300;
      I_MARValue = 16'h0040; I_RegWEn = 1'b1;
      @(negedge I_CLOCK); #1;
      I_EX_Valid = 1'b0;
      @(posedge I_CLOCK);
      check_eq("pre_rst_req", {31'h0, O_DMemReq}, 32'h1);
      #2;
      I_RESET_N = 1'b0;
      #1;
      check_eq("async_rst_req", {31'h0, O_DMemReq}, 32'h0);
      check_eq("async_rst_stall", {31'h0, O_MEMStall}, 32'h0);
      @(posedge I_CLOCK);
      I_RESET_N = 1'b1;
      @(negedge I_CLOCK); #1;
      I_DMemAck = 1'b1; I_DMemRData = 16'h7777;
      @(negedge I_CLOCK); #1;
      I_DMemAck = 1'b0;
      @(posedge I_CLOCK);
      check_eq("late_ack_req", {31'h0, O_DMemReq}, 32'h0);
      check_eq("late_ack_valid", {31'h0, O_MEM_Valid}, 32'h0);
      run_alu(16'h0320, 16'h0042, 1'b1, 1'b0, 1'b1);

      repeat (2) @(posedge I_CLOCK);
      check_eq("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
